// File: rtl/reaction_sequencer_pkg.sv
// Shared types and constants for the reaction timer sequencer.
// Holds the FSM state encoding, counter width and LFSR feedback helper.
package reaction_pkg;

    localparam int CNT_W = 14;

    // Fibonacci feedback taps 16/14/13/11 expressed as a bit mask
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        GAP   = 2'd2,
        GO    = 2'd3
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/reaction_sequencer_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR providing the random wait delay.
module lfsr16 import reaction_pkg::*; #(
    parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        areset,
    output logic [15:0] q
);

    // Advance one step every cycle; seed must be nonzero or the sequence locks up
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            q <= SEED;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/reaction_sequencer.sv
// Reaction timer sequencer: random wait, GO lamp, reaction measurement,
// false-start and timeout detection. Owns the shared counter's enable/limit.
module reaction_sequencer import reaction_pkg::*; #(
    parameter int          MIN_DELAY = 1000,
    parameter int          RAND_BITS = 11,
    parameter int          MAX_REACT = 9999,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             start,
    input  logic             react,
    output logic             cnt_enable,
    output logic [CNT_W-1:0] cnt_limit,
    input  logic             cnt_done,
    input  logic [CNT_W-1:0] cnt_value,
    output logic             led_go,
    output logic             busy,
    output logic [CNT_W-1:0] result_ms,
    output logic             result_valid,
    output logic             foul,
    output logic             timeout
);

    logic [15:0]      lfsr_s;
    logic [CNT_W-1:0] delay_s;
    logic             lfsr_unused_s;
    state_t           state_r;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .areset (areset),
        .q      (lfsr_s)
    );

    assign lfsr_unused_s = ^lfsr_s[15:RAND_BITS];

    // Wait length for the next round, taken from whatever the LFSR holds on the start cycle
    always_comb begin
        delay_s = CNT_W'(MIN_DELAY) + CNT_W'(lfsr_s[RAND_BITS-1:0]);
    end

    // Round sequencing; every output is a register updated on the state transition
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_r      <= IDLE;
            cnt_enable   <= 1'b0;
            cnt_limit    <= '0;
            led_go       <= 1'b0;
            busy         <= 1'b0;
            result_ms    <= '0;
            result_valid <= 1'b0;
            foul         <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r    <= ARMED;
                        cnt_limit  <= delay_s;
                        cnt_enable <= 1'b1;
                        busy       <= 1'b1;
                        foul       <= 1'b0;
                        timeout    <= 1'b0;
                    end
                end
                ARMED: begin
                    // react takes priority over a coincident done
                    if (react) begin
                        state_r    <= IDLE;
                        cnt_enable <= 1'b0;
                        busy       <= 1'b0;
                        foul       <= 1'b1;
                    end else if (cnt_done) begin
                        state_r    <= GAP;
                        cnt_enable <= 1'b0;
                        cnt_limit  <= CNT_W'(MAX_REACT);
                    end
                end
                GAP: begin
                    state_r    <= GO;
                    cnt_enable <= 1'b1;
                    led_go     <= 1'b1;
                end
                GO: begin
                    if (react) begin
                        state_r      <= IDLE;
                        cnt_enable   <= 1'b0;
                        led_go       <= 1'b0;
                        busy         <= 1'b0;
                        result_ms    <= cnt_value;
                        result_valid <= 1'b1;
                    end else if (cnt_done) begin
                        state_r      <= IDLE;
                        cnt_enable   <= 1'b0;
                        led_go       <= 1'b0;
                        busy         <= 1'b0;
                        result_ms    <= CNT_W'(MAX_REACT);
                        result_valid <= 1'b1;
                        timeout      <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    cnt_enable <= 1'b0;
                    led_go     <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
